ctr_drbg_update_engine: RTL and testbench
=========================================

Name: ctr_drbg_update_engine

Overview:
- Parametrised CTR_DRBG Update engine per SP 800-90A §10.2.1.2; successor to the fixed AES-256 update block.
- Supports AES-128 or AES-256 key length and a configurable counter-field width (ctr_len).
- Drives an external 128-bit block-cipher core through a req/ack handshake, so one AES core can be shared with the generate path.
- Sits between the instantiate/reseed/generate sequencer and the AES core.

Parameters:
- KEYLEN, 256, cipher key length in bits; legal values 128 or 256. Derived: SEEDLEN = KEYLEN+128, NBLK = SEEDLEN/128 (2 or 3).
- CTR_LEN, 128, width of the low V field that increments; legal range 4..128. Bits above CTR_LEN are never modified.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- provided_data  in  SEEDLEN  XOR operand; all-zero for no-derivation calls.
- key_in  in  KEYLEN  current Key.
- v_in  in  128  current V.
- busy  out  1  high from the edge that samples start until the edge that asserts done.
- done  out  1  one-cycle pulse; key_out/v_out valid from this cycle on.
- key_out  out  KEYLEN  new Key.
- v_out  out  128  new V.
- aes_req  out  1  cipher request; held until acknowledged.
- aes_key  out  KEYLEN  cipher key; equals the latched key_in.
- aes_block  out  128  plaintext block; the current V.
- aes_ack  in  1  cipher response valid; aes_result is captured on the edge where aes_req&&aes_ack.
- aes_result  in  128  ciphertext.

Behaviour:
- Reset: state=IDLE; busy, done, aes_req, key_out, v_out, aes_key, aes_block, internal temp and block counter all 0. Takes effect immediately, including mid-operation. aes_req drops asynchronously and any outstanding cipher response is ignored after release.
- FSM states: IDLE, INC, REQ, FIN.
- IDLE + start: latch key_in, v_in, provided_data; clear blk counter; go to INC; busy=1. Inputs may change afterwards without effect.
- INC (1 cycle): V[CTR_LEN-1:0] <= V[CTR_LEN-1:0]+1 mod 2^CTR_LEN; V[127:CTR_LEN] is unchanged. Go to REQ.
- REQ: aes_req=1 with aes_block=V and aes_key stable. On an edge with aes_ack=1:
  - store aes_result into temp slot blk; slot 0 is the most significant, so temp = blk0||blk1||...
  - if blk < NBLK-1: blk++ and go to INC; else go to FIN.
  - aes_req is low in INC and FIN. An ack outside REQ is ignored.
- FIN (1 cycle): t = temp ^ provided_data; key_out <= t[SEEDLEN-1 -: KEYLEN]; v_out <= t[127:0]; done=1 for this cycle; busy=0; go to IDLE.
- Latency with an ack in the first REQ cycle: done is high in the cycle after the (2*NBLK+1)-th rising edge following the start-sampling edge, i.e. 7 edges for KEYLEN=256 and 5 edges for KEYLEN=128. Each cycle of ack delay adds one cycle.
- start while busy: ignored, with no effect on the current operation.
- start in the same cycle as done (FIN): ignored; it is accepted from IDLE on the next cycle.
- key_out/v_out hold their values until the next FIN or reset.

Test Plan:
- Bench cipher model for all tests: aes_result = aes_block ^ aes_key[KEYLEN-1 -: 128], ack same cycle unless stated.
- KEYLEN=128, CTR_LEN=128, key=0, V=0, data=0 -> blocks 1,2; key_out=128'h1, v_out=128'h2; done on edge 5; busy high for 5 cycles.
- KEYLEN=256, key=0, V=128'hFFFF..FF, data=0 -> counter wraps to 0; key_out={128'h0,128'h1}, v_out=128'h2; done on edge 7.
- KEYLEN=256, CTR_LEN=32, key=0, V=128'hAAAA..AA_FFFFFFFF, data=384'hA5..A5 -> blocks AAAA..AA_00000000/01/02, each XOR A5; upper 96 bits never incremented.
- Backpressure: ack delayed 5 cycles per block (KEYLEN=256) -> aes_req, aes_block and aes_key stable while waiting; done on edge 22; same result as the no-delay run.
- start pulsed mid-operation, and again in the FIN cycle -> both ignored; exactly one done pulse; outputs match a single run.
- rst asserted during second REQ -> aes_req, busy and outputs zero immediately. A late ack after reset is ignored. A fresh start then completes correctly.

Source files
------------

// File: rtl/ctr_drbg_update_engine.sv
// ctr_drbg_update_engine: CTR_DRBG Update (Key, V refresh) driving a shared 128-bit block cipher over req/ack.
module ctr_drbg_update_engine #(
  parameter int KEYLEN = 256,
  parameter int CTR_LEN = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEYLEN+127:0] provided_data,
  input  logic [KEYLEN-1:0]   key_in,
  input  logic [127:0]        v_in,
  output logic                busy,
  output logic                done,
  output logic [KEYLEN-1:0]   key_out,
  output logic [127:0]        v_out,
  output logic                aes_req,
  output logic [KEYLEN-1:0]   aes_key,
  output logic [127:0]        aes_block,
  input  logic                aes_ack,
  input  logic [127:0]        aes_result
);
  localparam int SEEDLEN = KEYLEN + 128;
  localparam int NBLK = SEEDLEN / 128;
  localparam logic [127:0] CTR_MASK = {128{1'b1}} >> (128 - CTR_LEN);
  typedef enum logic [1:0] {IDLE, INC, REQ, FIN} state_t;
  state_t state;
  logic [1:0] blk;
  logic [SEEDLEN-1:0] temp, data, t;
  logic [127:0] v_inc;
  // the carry out of the counter field is masked off, so bits above CTR_LEN never move
  always_comb begin
    v_inc = (aes_block & ~CTR_MASK) | ((aes_block + 128'd1) & CTR_MASK);
    t = temp ^ data;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      aes_req <= 1'b0;
      key_out <= '0;
      v_out <= '0;
      aes_key <= '0;
      aes_block <= '0;
      temp <= '0;
      data <= '0;
      blk <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start && !done) begin
          aes_key <= key_in;
          aes_block <= v_in;
          data <= provided_data;
          temp <= '0;
          blk <= '0;
          busy <= 1'b1;
          state <= INC;
        end
        INC: begin
          aes_block <= v_inc;
          aes_req <= 1'b1;
          state <= REQ;
        end
        // blocks shift in from the bottom so the first ciphertext ends up most significant
        REQ: if (aes_ack) begin
          temp <= {temp[SEEDLEN-129:0], aes_result};
          aes_req <= 1'b0;
          blk <= blk + 2'd1;
          state <= (blk == 2'(NBLK - 1)) ? FIN : INC;
        end
        FIN: begin
          key_out <= t[SEEDLEN-1 -: KEYLEN];
          v_out <= t[127:0];
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ctr_drbg_update_engine.sv
// tb_ctr_drbg_update_engine: three parameterisations (128/128, 256/128, 256/32) against an arithmetic Update model.
module tb_ctr_drbg_update_engine;
  logic clk = 0, rst = 1, ack_force = 0;
  int ack_delay = 0;
  logic [255:0] key_in;
  logic [127:0] v_in;
  logic [383:0] data;
  logic start [3];
  logic busy [3], done [3], req [3], ack [3];
  logic [255:0] kout [3], akey [3];
  logic [127:0] vout [3], ablk [3], res [3];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int KL = (g == 0) ? 128 : 256;
    localparam int CL = (g == 2) ? 32 : 128;
    logic [KL-1:0] ko, ak;
    int wc;
    ctr_drbg_update_engine #(.KEYLEN(KL), .CTR_LEN(CL)) dut (
      .clk(clk), .rst(rst), .start(start[g]), .provided_data(data[KL+127:0]),
      .key_in(key_in[KL-1:0]), .v_in(v_in), .busy(busy[g]), .done(done[g]),
      .key_out(ko), .v_out(vout[g]), .aes_req(req[g]), .aes_key(ak),
      .aes_block(ablk[g]), .aes_ack(ack[g]), .aes_result(res[g]));
    assign kout[g] = 256'(ko);
    assign akey[g] = 256'(ak);
    assign res[g] = ablk[g] ^ ak[KL-1 -: 128];
    assign ack[g] = ack_force || (req[g] && wc >= ack_delay);
    always @(posedge clk or posedge rst)
      if (rst) wc <= 0;
      else wc <= (req[g] && !ack[g]) ? wc + 1 : 0;
  end
  typedef struct {
    int g; logic [255:0] k; logic [127:0] v; logic [383:0] d; int dly; bit mid;
    logic [255:0] ek; logic [127:0] ev; int edges;
  } vec_t;
  vec_t tbl [5];
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic int klen(input int g);
    return (g == 0) ? 128 : 256;
  endfunction
  function automatic int clen(input int g);
    return (g == 2) ? 32 : 128;
  endfunction
  // Update from first principles: counter field treated as an integer modulo 2^ctr_len
  function automatic void model(input int kl, input int cl, input logic [255:0] key, input logic [127:0] v,
                                input logic [383:0] d, output logic [255:0] ko, output logic [127:0] vo);
    logic [383:0] t = '0;
    logic [128:0] m, hi, lo;
    logic [255:0] k;
    k = (kl == 128) ? {128'b0, key[127:0]} : key;
    if (kl == 128) d = {128'b0, d[255:0]};
    m = 129'(1) << cl;
    for (int i = 0; i < kl / 128 + 1; i++) begin
      hi = {1'b0, v} / m;
      lo = ({1'b0, v} % m + 129'd1) % m;
      v = 128'(hi * m + lo);
      t = (t << 128) | 384'(v ^ 128'(k >> (kl - 128)));
    end
    t = t ^ d;
    vo = t[127:0];
    ko = 256'(t >> 128);
  endfunction
  task automatic run(input int g, input logic [255:0] k, input logic [127:0] v, input logic [383:0] d,
                     input int dly, input bit mid, input logic [255:0] ek, input logic [127:0] ev, input int edges);
    int n, bc;
    bit stable, pr, pa, extra;
    logic [127:0] pb;
    logic [255:0] pk, kl;
    kl = (g == 0) ? {128'b0, k[127:0]} : k;
    ack_delay = dly;
    @(negedge clk);
    key_in = k; v_in = v; data = d; start[g] = 1;
    @(negedge clk);
    start[g] = 0;
    n = 0; bc = int'(busy[g]); stable = 1;
    pr = req[g]; pa = ack[g]; pb = ablk[g]; pk = akey[g];
    while (!done[g] && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      bc += int'(busy[g]);
      if (pr && !pa && !(req[g] && ablk[g] == pb && akey[g] == pk)) stable = 0;
      if (req[g] && akey[g] != kl) stable = 0;
      start[g] = mid && (n == 3 || n == edges - 1);
      if (mid && n == 3) begin key_in = ~k; v_in = ~v; data = ~d; end
      pr = req[g]; pa = ack[g]; pb = ablk[g]; pk = akey[g];
    end
    start[g] = 0;
    chk("latency", 256'(n), 256'(edges));
    chk("busy_cycles", 256'(bc), 256'(edges));
    chk("req_stable", 256'(stable), 256'd1);
    chk("key_out", kout[g], ek);
    chk("v_out", vout[g], ev);
    extra = 0;
    repeat (mid ? 10 : 1) begin
      @(negedge clk);
      if (done[g] || busy[g]) extra = 1;
    end
    chk("single_done", 256'(extra), 256'd0);
  endtask
  initial begin
    logic [255:0] k, ek;
    logic [127:0] v, ev;
    logic [383:0] d;
    int g, dly;
    bit spurious;
    tbl[0] = '{0, '0, '0, '0, 0, 0, 256'h1, 128'h2, 5};
    tbl[1] = '{1, '0, {128{1'b1}}, '0, 0, 0, 256'h1, 128'h2, 7};
    tbl[2] = '{2, '0, {{12{8'hAA}}, 32'hFFFFFFFF}, {48{8'hA5}}, 0, 0,
               {{12{8'h0F}}, 32'hA5A5A5A5, {12{8'h0F}}, 32'hA5A5A5A4}, {{12{8'h0F}}, 32'hA5A5A5A7}, 7};
    tbl[3] = '{1, '0, {128{1'b1}}, '0, 5, 0, 256'h1, 128'h2, 22};
    tbl[4] = '{2, '0, {{12{8'hAA}}, 32'hFFFFFFFF}, {48{8'hA5}}, 0, 1,
               {{12{8'h0F}}, 32'hA5A5A5A5, {12{8'h0F}}, 32'hA5A5A5A4}, {{12{8'h0F}}, 32'hA5A5A5A7}, 7};
    for (int i = 0; i < 3; i++) start[i] = 0;
    key_in = '0; v_in = '0; data = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_busy", 256'(busy[i]), 256'd0);
      chk("rst_req", 256'(req[i]), 256'd0);
      chk("rst_outs", kout[i] | 256'(vout[i]) | akey[i] | 256'(ablk[i]) | 256'(done[i]), 256'd0);
    end
    rst = 0;
    foreach (tbl[i]) run(tbl[i].g, tbl[i].k, tbl[i].v, tbl[i].d, tbl[i].dly, tbl[i].mid, tbl[i].ek, tbl[i].ev, tbl[i].edges);
    for (int i = 0; i < 30; i++) begin
      g = $urandom_range(2);
      dly = $urandom_range(3);
      k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      v = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(3) == 0) v[31:0] = '1;
      d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
           $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      model(klen(g), clen(g), k, v, d, ek, ev);
      run(g, k, v, d, dly, 0, ek, ev, 2 * (klen(g) / 128 + 1) + 1 + (klen(g) / 128 + 1) * dly);
    end
    ack_delay = 0;
    @(negedge clk);
    key_in = {8{32'h1234_5678}}; v_in = '1; data = '1; start[1] = 1;
    @(negedge clk);
    start[1] = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("second_req", 256'(req[1]), 256'd1);
    rst = 1;
    #1;
    chk("arst_req", 256'(req[1]), 256'd0);
    chk("arst_busy", 256'(busy[1]), 256'd0);
    chk("arst_outs", kout[1] | 256'(vout[1]) | akey[1] | 256'(ablk[1]) | 256'(done[1]), 256'd0);
    @(negedge clk);
    rst = 0;
    ack_force = 1;
    spurious = 0;
    repeat (3) begin
      @(negedge clk);
      if (done[1] || busy[1] || kout[1] != 0 || vout[1] != 0) spurious = 1;
    end
    ack_force = 0;
    chk("late_ack_ignored", 256'(spurious), 256'd0);
    k = {8{32'hDEAD_BEEF}};
    v = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    d = {12{32'h5A5A_1234}};
    model(256, 128, k, v, d, ek, ev);
    run(1, k, v, d, 0, 0, ek, ev, 7);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
